// File: rtl/alux_pkg.sv
// Shared constants for the complex-ALU arbiter: operand widths, opcode map,
// FSM state encoding and the opcode legality helper.
package alux_pkg;

  localparam int COMPLEX_W = 64;
  localparam int PART_W    = 32;
  localparam int OPR_W     = 5;

  typedef logic [OPR_W-1:0] opr_t;

  typedef struct packed {
    logic [PART_W-1:0] re;
    logic [PART_W-1:0] im;
  } complex_t;

  localparam opr_t OP_A     = 5'd0;
  localparam opr_t OP_B     = 5'd1;
  localparam opr_t OP_ADD   = 5'd2;
  localparam opr_t OP_SUB   = 5'd3;
  localparam opr_t OP_MUL   = 5'd4;
  localparam opr_t OP_CONJA = 5'd5;
  localparam opr_t OP_CONJB = 5'd6;
  localparam opr_t OP_NEGA  = 5'd7;
  localparam opr_t OP_NEGB  = 5'd8;
  localparam opr_t OP_MODA  = 5'd9;
  localparam opr_t OP_MODB  = 5'd10;
  localparam opr_t OP_MAX   = OP_MODB;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_REJECT = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  function automatic logic opr_legal(input opr_t opr, input int max_opr);
    return int'(opr) <= max_opr;
  endfunction

endpackage

// File: rtl/alux_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] sel;
  logic         found;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (IW'(gi) >= ptr);
  end

  // Requests at/after the pointer take priority; otherwise fall back to the
  // wrapped-around lower half.
  assign masked = req & hi_mask;
  assign sel    = (|masked) ? masked : req;
  assign any    = |req;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel[i] && !found) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alux_arbiter.sv
// Shares one complex ALU among N_REQ requesters: round-robin grant, operand
// capture, start/done handshake with a watchdog, and a one-cycle ack.
module alux_arbiter
  import alux_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64,
  parameter int MAX_OPR = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [OPR_W*N_REQ-1:0]     req_opr,
  input  logic [COMPLEX_W*N_REQ-1:0] req_a,
  input  logic [COMPLEX_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]           ack,
  output logic [COMPLEX_W-1:0]       result,
  output logic                       err,
  output logic                       busy,
  output logic                       alu_start,
  output logic [OPR_W-1:0]           alu_opr,
  output logic [COMPLEX_W-1:0]       alu_inA,
  output logic [COMPLEX_W-1:0]       alu_inB,
  input  logic                       alu_done,
  input  logic [COMPLEX_W-1:0]       alu_out
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  logic [2:0]           state_reg;
  logic [IW-1:0]        ptr_reg;
  logic [IW-1:0]        winner_reg;
  logic [TW-1:0]        timer_reg;
  logic [COMPLEX_W-1:0] result_reg;
  logic                 err_reg;
  opr_t                 opr_reg;
  logic [COMPLEX_W-1:0] in_a_reg;
  logic [COMPLEX_W-1:0] in_b_reg;

  logic [N_REQ-1:0]     grant;
  logic [IW-1:0]        grant_idx;
  logic                 grant_any;
  logic [IW-1:0]        ptr_next;

  opr_t                 opr_terms [N_REQ];
  logic [COMPLEX_W-1:0] a_terms   [N_REQ];
  logic [COMPLEX_W-1:0] b_terms   [N_REQ];
  opr_t                 sel_opr;
  logic [COMPLEX_W-1:0] sel_a;
  logic [COMPLEX_W-1:0] sel_b;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (grant),
    .index (grant_idx),
    .any   (grant_any)
  );

  // One-hot AND-OR operand mux keyed by the arbiter grant; ack decode per lane.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign opr_terms[gi] = req_opr[gi*OPR_W +: OPR_W] & {OPR_W{grant[gi]}};
    assign a_terms[gi]   = req_a[gi*COMPLEX_W +: COMPLEX_W] & {COMPLEX_W{grant[gi]}};
    assign b_terms[gi]   = req_b[gi*COMPLEX_W +: COMPLEX_W] & {COMPLEX_W{grant[gi]}};
    assign ack[gi]       = (state_reg == ST_RESP) && (winner_reg == IW'(gi));
  end

  always_comb begin
    sel_opr = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_opr = sel_opr | opr_terms[i];
      sel_a   = sel_a   | a_terms[i];
      sel_b   = sel_b   | b_terms[i];
    end
  end

  assign ptr_next = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      winner_reg <= '0;
      timer_reg  <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      opr_reg    <= '0;
      in_a_reg   <= '0;
      in_b_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            winner_reg <= grant_idx;
            opr_reg    <= sel_opr;
            in_a_reg   <= sel_a;
            in_b_reg   <= sel_b;
            ptr_reg    <= ptr_next;
            state_reg  <= opr_legal(sel_opr, MAX_OPR) ? ST_ISSUE : ST_REJECT;
          end
        end
        ST_ISSUE: begin
          timer_reg <= '0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          // done is checked first so it wins over a coinciding timeout
          if (alu_done) begin
            result_reg <= alu_out;
            err_reg    <= 1'b0;
            state_reg  <= ST_RESP;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            result_reg <= '0;
            err_reg    <= 1'b1;
            state_reg  <= ST_RESP;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ST_REJECT: begin
          result_reg <= '0;
          err_reg    <= 1'b1;
          state_reg  <= ST_RESP;
        end
        ST_RESP: begin
          result_reg <= '0;
          err_reg    <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign alu_start = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign alu_opr   = opr_reg;
  assign alu_inA   = in_a_reg;
  assign alu_inB   = in_b_reg;
  assign result    = result_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_alux_arbiter.sv
// Self-checking bench for alux_arbiter: table of single-request vectors plus
// hand sequences for round-robin, mid-operation reset and start gaps.
module tb_alux_arbiter;

  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 64;
  localparam int MAX_OPR = 10;

  logic                clock = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req;
  logic [5*N_REQ-1:0]  req_opr;
  logic [64*N_REQ-1:0] req_a;
  logic [64*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    ack;
  logic [63:0]         result;
  logic                err;
  logic                busy;
  logic                alu_start;
  logic [4:0]          alu_opr;
  logic [63:0]         alu_inA;
  logic [63:0]         alu_inB;
  logic                alu_done;
  logic [63:0]         alu_out;

  alux_arbiter #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT),
    .MAX_OPR (MAX_OPR)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_opr   (req_opr),
    .req_a     (req_a),
    .req_b     (req_b),
    .ack       (ack),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .alu_start (alu_start),
    .alu_opr   (alu_opr),
    .alu_inA   (alu_inA),
    .alu_inB   (alu_inB),
    .alu_done  (alu_done),
    .alu_out   (alu_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          idx;
    logic [4:0]  opr;
    logic [63:0] a;
    logic [63:0] b;
    int          lat;
    logic [63:0] res;
    logic        err;
    int          cyc;
    logic        start;
  } vec_t;

  typedef struct {
    int          idx;
    logic [63:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  int   errors = 0;
  int   checks = 0;
  int   acks = 0;
  int   start_rises = 0;
  int   alu_cnt = 0;
  int   alu_lat = 1;
  logic start_prev = 1'b0;
  logic start_seen = 1'b0;

  function automatic logic [63:0] bench_alu(input logic [4:0] opr, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [31:0] re;
    logic [31:0] im;
    case (opr)
      5'd0: return a;
      5'd1: return b;
      5'd2: begin re = a[63:32] + b[63:32]; im = a[31:0] + b[31:0]; return {re, im}; end
      5'd3: begin re = a[63:32] - b[63:32]; im = a[31:0] - b[31:0]; return {re, im}; end
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic score_ack();
    int idx;
    int pos;
    idx = -1;
    pos = -1;
    acks++;
    check("ack_onehot", 64'($onehot(ack)), 64'd1);
    for (int i = 0; i < N_REQ; i++) if (ack[i]) idx = i;
    for (int k = 0; k < sb.size(); k++) if (pos < 0 && sb[k].idx == idx) pos = k;
    if (pos < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_unexpected: got ack=%b expected no ack", ack);
    end else begin
      check($sformatf("ack%0d_result", idx), result, sb[pos].res);
      check($sformatf("ack%0d_err", idx), 64'(err), 64'(sb[pos].err));
      $display("ack req%0d result=%h err=%0b", idx, result, err);
      sb.delete(pos);
    end
  endtask

  // One clock: ALU model, start-edge bookkeeping and scoreboard, all at negedge.
  task automatic tick();
    @(negedge clock);
    if (alu_start) alu_cnt++;
    else alu_cnt = 0;
    alu_done = (alu_cnt == alu_lat + 1);
    alu_out  = alu_done ? bench_alu(alu_opr, alu_inA, alu_inB) : 64'hDEAD_BEEF_0BAD_F00D;
    if (alu_start && !start_prev) start_rises++;
    start_prev = alu_start;
    if (alu_start) start_seen = 1'b1;
    if (ack != '0) score_ack();
  endtask

  task automatic set_req(input int idx, input logic [4:0] opr, input logic [63:0] a,
                         input logic [63:0] b);
    req_opr[5*idx +: 5]  = opr;
    req_a[64*idx +: 64]  = a;
    req_b[64*idx +: 64]  = b;
  endtask

  task automatic push_exp(input int idx, input logic [63:0] res, input logic e);
    exp_t x;
    x.idx = idx;
    x.res = res;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_result"}, result, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int n;
    bit got;
    alu_lat = v.lat;
    set_req(v.idx, v.opr, v.a, v.b);
    req[v.idx] = 1'b1;
    push_exp(v.idx, v.res, v.err);
    start_seen = 1'b0;
    n = 1;
    got = 1'b0;
    while (!got && n < 200) begin
      tick();
      n++;
      if (n == 2) check($sformatf("v%0d_busy", vi), 64'(busy), 64'd1);
      if (ack[v.idx]) begin
        got = 1'b1;
        req[v.idx] = 1'b0;
      end
    end
    check($sformatf("v%0d_ack_seen", vi), 64'(got), 64'd1);
    check($sformatf("v%0d_latency", vi), 64'(n), 64'(v.cyc));
    check($sformatf("v%0d_alu_started", vi), 64'(start_seen), 64'(v.start));
    req[v.idx] = 1'b0;
    tick();
    check_idle($sformatf("v%0d_after", vi));
  endtask

  initial begin
    int   a0;
    int   r0;
    int   left[N_REQ];
    int   prev;
    int   idx;

    vecs[0] = '{0, 5'd2,  {32'd1, 32'd2},     {32'd3, 32'd4},     2,    {32'd4, 32'd6},   1'b0, 5,  1'b1};
    vecs[1] = '{1, 5'd3,  {32'd10, 32'd20},   {32'd3, 32'd4},     1,    {32'd7, 32'd16},  1'b0, 4,  1'b1};
    vecs[2] = '{1, 5'd20, {32'd5, 32'd5},     {32'd6, 32'd6},     1,    64'd0,            1'b1, 3,  1'b0};
    vecs[3] = '{0, 5'd0,  {32'd5, 32'd6},     {32'd9, 32'd9},     3,    {32'd5, 32'd6},   1'b0, 6,  1'b1};
    vecs[4] = '{1, 5'd11, {32'd1, 32'd1},     {32'd2, 32'd2},     1,    64'd0,            1'b1, 3,  1'b0};
    vecs[5] = '{0, 5'd10, {32'hF0, 32'h1},    {32'h0F, 32'h3},    1,    {32'hFF, 32'h2},  1'b0, 4,  1'b1};
    vecs[6] = '{0, 5'd2,  {32'd1, 32'd1},     {32'd1, 32'd1},     1000, 64'd0,            1'b1, 67, 1'b1};
    vecs[7] = '{1, 5'd1,  {32'd1, 32'd1},     {32'd7, 32'd8},     1,    {32'd7, 32'd8},   1'b0, 4,  1'b1};
    vecs[8] = '{0, 5'd3,  {32'd100, 32'd50},  {32'd1, 32'd2},     64,   {32'd99, 32'd48}, 1'b0, 67, 1'b1};
    vecs[9] = '{1, 5'd31, {32'd3, 32'd3},     {32'd4, 32'd4},     1,    64'd0,            1'b1, 3,  1'b0};

    reset    = 1'b1;
    req      = '0;
    req_opr  = '0;
    req_a    = '0;
    req_b    = '0;
    alu_done = 1'b0;
    alu_out  = '0;
    repeat (3) tick();
    check_idle("reset");
    check("reset_alu_start", 64'(alu_start), 64'd0);
    check("reset_alu_opr", 64'(alu_opr), 64'd0);
    check("reset_alu_inA", alu_inA, 64'd0);
    check("reset_alu_inB", alu_inB, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset while WAITing on an ALU that never answers: no ack may follow.
    alu_lat = 1000;
    set_req(0, 5'd2, {32'd1, 32'd1}, {32'd2, 32'd2});
    req[0] = 1'b1;
    repeat (4) tick();
    check("rst_mid_in_wait", 64'(alu_start), 64'd1);
    reset = 1'b1;
    req   = '0;
    tick();
    check_idle("rst_mid");
    check("rst_mid_alu_start", 64'(alu_start), 64'd0);
    check("rst_mid_alu_opr", 64'(alu_opr), 64'd0);
    check("rst_mid_alu_inA", alu_inA, 64'd0);
    reset = 1'b0;
    a0 = acks;
    repeat (6) tick();
    check("rst_mid_no_ack", 64'(acks - a0), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);

    // Both requesters held: grants must alternate starting from requester 0.
    alu_lat = 1;
    set_req(0, 5'd2, {32'd1, 32'd1}, {32'd2, 32'd2});
    set_req(1, 5'd3, {32'd9, 32'd9}, {32'd4, 32'd4});
    for (int k = 0; k < 3; k++) begin
      push_exp(0, {32'd3, 32'd3}, 1'b0);
      push_exp(1, {32'd5, 32'd5}, 1'b0);
    end
    left[0] = 3;
    left[1] = 3;
    prev = -1;
    r0 = start_rises;
    req = 2'b11;
    for (int c = 0; c < 100 && (left[0] + left[1]) > 0; c++) begin
      tick();
      if (ack != '0) begin
        idx = ack[1] ? 1 : 0;
        if (prev < 0) check("rr_first_grant", 64'(idx), 64'd0);
        else check("rr_alternate", 64'(idx), 64'(1 - prev));
        prev = idx;
        left[idx]--;
        if (left[idx] == 0) req[idx] = 1'b0;
      end
    end
    check("rr_all_served", 64'(left[0] + left[1]), 64'd0);
    req = '0;
    tick();
    check("rr_fresh_starts", 64'(start_rises - r0), 64'd6);
    check_idle("rr_after");

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
